// File: rtl/surf_digitize_scheduler_if.sv
// Digitizer dispatch handshake between surf_digitize_scheduler (master) and the LAB digitizer (slave).
// dig_req_o stays high with dig_buf_o/dig_id_o stable until dig_ack_i is sampled. dig_done_i then ends the job.
// done_o pulses for one cycle with dig_buf_o still valid.
interface surf_digitize_scheduler_if;
  logic        dig_req_o;
  logic [1:0]  dig_buf_o;
  logic [31:0] dig_id_o;
  logic        dig_ack_i;
  logic        dig_done_i;
  logic        done_o;

  modport master (
    output dig_req_o, dig_buf_o, dig_id_o, done_o,
    input  dig_ack_i, dig_done_i
  );

  modport slave (
    input  dig_req_o, dig_buf_o, dig_id_o, done_o,
    output dig_ack_i, dig_done_i
  );
endinterface

// File: rtl/surf_digitize_scheduler.sv
// Round-robin digitize request queue with per-buffer event ID capture and collision counting.
// Optional BUSY watchdog: define SURF_DIG_TIMEOUT_EN.
module surf_digitize_scheduler #(
  parameter int NBUF           = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                      clk33_i,
  input  logic                      rst_i,
  input  logic [NBUF-1:0]           digitize_i,
  input  logic                      event_id_wr_i,
  input  logic [$clog2(NBUF)-1:0]   event_id_buffer_i,
  input  logic [31:0]               event_id_i,
  surf_digitize_scheduler_if.master dig,
  output logic [NBUF-1:0]           pending_o,
  output logic                      overflow_o,
  output logic [7:0]                drop_count_o,
  output logic                      timeout_o,
  output logic [1:0]                state_o
);
  localparam int IW = $clog2(NBUF);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_BUSY = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state;
  logic [IW-1:0]   last;
  logic [31:0]     id_store [NBUF];
  logic [IW-1:0]   sel;
  logic [IW-1:0]   cand;
  logic            sel_valid;
  logic [NBUF-1:0] active_mask;
  logic [NBUF-1:0] collide;
  logic [NBUF-1:0] clear_mask;
  logic [NBUF-1:0] pending_next;

`ifdef SURF_DIG_TIMEOUT_EN
  logic [15:0]     tmo_cnt;
`else
  logic            unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

  assign state_o = state;

  // pending_o is the queue register itself. The scan runs from the farthest
  // candidate down, so the candidate nearest to last+1 wins.
  always_comb begin
    sel       = '0;
    sel_valid = 1'b0;
    cand      = '0;
    for (int i = NBUF; i >= 1; i--) begin
      cand = last + IW'(i);
      if (pending_o[cand]) begin
        sel       = cand;
        sel_valid = 1'b1;
      end
    end
    active_mask = '0;
    if (state == S_REQ || state == S_BUSY) active_mask[dig.dig_buf_o] = 1'b1;
    collide    = digitize_i & (pending_o | active_mask);
    clear_mask = '0;
    if (state == S_IDLE && sel_valid) clear_mask[sel] = 1'b1;
    pending_next = (pending_o & ~clear_mask) | (digitize_i & ~collide);
  end

  always_ff @(posedge clk33_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= S_IDLE;
      last          <= IW'(NBUF - 1);
      pending_o     <= '0;
      overflow_o    <= 1'b0;
      drop_count_o  <= '0;
      timeout_o     <= 1'b0;
      dig.dig_req_o <= 1'b0;
      dig.dig_buf_o <= '0;
      dig.dig_id_o  <= '0;
      dig.done_o    <= 1'b0;
      for (int i = 0; i < NBUF; i++) id_store[i] <= '0;
`ifdef SURF_DIG_TIMEOUT_EN
      tmo_cnt       <= '0;
`endif
    end else begin
      if (event_id_wr_i) id_store[event_id_buffer_i] <= event_id_i;
      pending_o  <= pending_next;
      overflow_o <= |collide;
      if (|collide && drop_count_o != 8'hFF) drop_count_o <= drop_count_o + 8'd1;
      dig.done_o <= 1'b0;
      timeout_o  <= 1'b0;

      case (state)
        S_IDLE: begin
          if (sel_valid) begin
            dig.dig_buf_o <= sel;
            dig.dig_id_o  <= id_store[sel];
            dig.dig_req_o <= 1'b1;
            last          <= sel;
            state         <= S_REQ;
          end
        end
        S_REQ: begin
          if (dig.dig_ack_i) begin
            dig.dig_req_o <= 1'b0;
            state         <= S_BUSY;
`ifdef SURF_DIG_TIMEOUT_EN
            tmo_cnt       <= '0;
`endif
          end
        end
        S_BUSY: begin
          if (dig.dig_done_i) begin
            dig.done_o <= 1'b1;
            state      <= S_DONE;
          end
`ifdef SURF_DIG_TIMEOUT_EN
          else if (tmo_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
            timeout_o <= 1'b1;
            state     <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
`endif
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
